// File: rtl/key_led_pkg.sv
// Shared definitions for the multi-key debounce / LED controller.
//   - LED mode encodings
//   - per-channel debounce FSM state type
//   - clog2 helper for sizing counters
package key_led_pkg;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROTATE = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StPfilt,
        StDown,
        StRfilt
    } deb_state_e;

    // Bits needed to hold values 0..value-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM and press/click/long classifier.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   key_i        raw key, active-low, asynchronous
//   key_state_o  debounced level, 1 = released
//   key_press_o  1-cycle pulse on confirmed press
//   key_click_o  1-cycle pulse on confirmed release when no long-press was seen
//   key_long_o   1-cycle pulse once the key has been held LONG_CYC cycles
module key_debounce_ch
    import key_led_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 8,
    parameter int unsigned LONG_CYC     = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic key_state_o,
    output logic key_press_o,
    output logic key_click_o,
    output logic key_long_o
);

    localparam int unsigned CntW = clog2(LONG_CYC);
    // The cycle that leaves IDLE/DOWN counts as the first stable sample, so the
    // confirming sample is the one whose increment would reach DEBOUNCE_CYC-1.
    localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYC - 2);
    localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYC - 2);
    localparam logic [CntW-1:0] HoldMax  = CntW'(LONG_CYC - 1);

    logic            sync1_q, sync2_q;
    deb_state_e      state_q;
    logic [CntW-1:0] filt_cnt_q;
    logic [CntW-1:0] hold_cnt_q;
    logic            long_seen_q;
    logic            key_state_q, press_q, click_q, long_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= StIdle;
            filt_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            long_seen_q <= 1'b0;
            key_state_q <= 1'b1;
            press_q     <= 1'b0;
            click_q     <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            click_q <= 1'b0;
            long_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!sync2_q) begin
                        state_q    <= StPfilt;
                        filt_cnt_q <= '0;
                    end
                end
                StPfilt: begin
                    if (sync2_q) begin
                        state_q <= StIdle;
                    end else if (filt_cnt_q == DebLast) begin
                        state_q     <= StDown;
                        hold_cnt_q  <= '0;
                        press_q     <= 1'b1;
                        key_state_q <= 1'b0;
                    end else begin
                        filt_cnt_q <= filt_cnt_q + CntW'(1);
                    end
                end
                StDown: begin
                    if (sync2_q) begin
                        state_q    <= StRfilt;
                        filt_cnt_q <= '0;
                    end else if (hold_cnt_q != HoldMax) begin
                        // Saturates at HoldMax so the long pulse fires only once per hold.
                        hold_cnt_q <= hold_cnt_q + CntW'(1);
                        if (hold_cnt_q == LongLast && !long_seen_q) begin
                            long_q      <= 1'b1;
                            long_seen_q <= 1'b1;
                        end
                    end
                end
                StRfilt: begin
                    if (!sync2_q) begin
                        // Release bounce: resume the hold with count and long_seen intact.
                        state_q <= StDown;
                    end else if (filt_cnt_q == DebLast) begin
                        state_q     <= StIdle;
                        key_state_q <= 1'b1;
                        click_q     <= !long_seen_q;
                        long_seen_q <= 1'b0;
                    end else begin
                        filt_cnt_q <= filt_cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign key_state_o = key_state_q;
    assign key_press_o = press_q;
    assign key_click_o = click_q;
    assign key_long_o  = long_q;

endmodule

// File: rtl/key_led_multi.sv
// N-channel debounced keys driving a mode-aware LED controller.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   key_in       raw keys, active-low, asynchronous
//   key_state    debounced levels, 1 = released
//   key_press    1-cycle pulse per confirmed press
//   key_click    1-cycle pulse per short press on release
//   key_long     1-cycle pulse per long-press
//   led_mode     0 STATIC, 1 BLINK, 2 ROTATE
//   led          LED drive, 1 = on
// Key 0 click increments the counter, key 1 click decrements it, key k>=2 click
// toggles bit (k-2) mod NUM_LEDS. Key 0 long cycles the mode, key 1 long clears.
module key_led_multi
    import key_led_pkg::*;
#(
    parameter int unsigned NUM_KEYS     = 4,
    parameter int unsigned NUM_LEDS     = 4,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned LONG_CYC     = 50_000_000,
    parameter int unsigned BLINK_CYC    = 12_500_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_click,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [1:0]          led_mode,
    output logic [NUM_LEDS-1:0] led
);

    localparam int unsigned TimW = clog2(BLINK_CYC);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .LONG_CYC    (LONG_CYC)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_i      (key_in[g]),
            .key_state_o(key_state[g]),
            .key_press_o(key_press[g]),
            .key_click_o(key_click[g]),
            .key_long_o (key_long[g])
        );
    end

    logic [NUM_LEDS-1:0] cnt_q, cnt_d;
    logic [NUM_LEDS-1:0] shadow_q, shadow_d;
    logic [NUM_LEDS-1:0] tog;
    logic [1:0]          mode_q, mode_d;
    logic [TimW-1:0]     timer_q, timer_d;
    logic                phase_q, phase_d;
    logic                tick;

    always_comb begin
        tog = '0;
        for (int k = 2; k < NUM_KEYS; k++) begin
            tog[(k - 2) % NUM_LEDS] = tog[(k - 2) % NUM_LEDS] ^ key_click[k];
        end

        // Inc/dec first, then toggles; simultaneous inc and dec cancel.
        cnt_d = cnt_q;
        if (key_click[0] && !key_click[1]) begin
            cnt_d = cnt_q + NUM_LEDS'(1);
        end else if (key_click[1] && !key_click[0]) begin
            cnt_d = cnt_q - NUM_LEDS'(1);
        end
        cnt_d = cnt_d ^ tog;

        mode_d = mode_q;
        if (key_long[0]) begin
            case (mode_q)
                MODE_STATIC: mode_d = MODE_BLINK;
                MODE_BLINK:  mode_d = MODE_ROTATE;
                default:     mode_d = MODE_STATIC;
            endcase
        end

        // Clear beats every other same-cycle event.
        if (key_long[1]) begin
            cnt_d  = '0;
            mode_d = MODE_STATIC;
        end

        tick = (mode_q != MODE_STATIC) && (timer_q == TimW'(BLINK_CYC - 1));

        if (key_long[0] || key_long[1] || mode_q == MODE_STATIC || tick) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TimW'(1);
        end

        phase_d = phase_q;
        if (key_long[0] || key_long[1]) begin
            phase_d = 1'b1;
        end else if (tick) begin
            phase_d = !phase_q;
        end

        // A counter change or entering ROTATE reloads the pattern, even on a tick.
        shadow_d = shadow_q;
        if ((mode_d == MODE_ROTATE && mode_q != MODE_ROTATE) || cnt_d != cnt_q) begin
            shadow_d = cnt_d;
        end else if (tick && mode_q == MODE_ROTATE) begin
            shadow_d = {shadow_q[NUM_LEDS-2:0], shadow_q[NUM_LEDS-1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            mode_q   <= MODE_STATIC;
            timer_q  <= '0;
            phase_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            mode_q   <= mode_d;
            timer_q  <= timer_d;
            phase_q  <= phase_d;
        end
    end

    always_comb begin
        case (mode_q)
            MODE_STATIC: led = cnt_q;
            MODE_BLINK:  led = phase_q ? cnt_q : '0;
            MODE_ROTATE: led = shadow_q;
            default:     led = '0;
        endcase
    end

    assign led_mode = mode_q;

endmodule

// File: tb/tb_key_led_multi.sv
// Bench for key_led_multi with small timing parameters.
module tb_key_led_multi;

    localparam int NK    = 4;
    localparam int NL    = 4;
    localparam int DEB   = 8;
    localparam int LONG  = 40;
    localparam int BLINK = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_in = '1;
    logic [NK-1:0] key_state, key_press, key_click, key_long;
    logic [1:0]    led_mode;
    logic [NL-1:0] led;

    key_led_multi #(
        .NUM_KEYS    (NK),
        .NUM_LEDS    (NL),
        .DEBOUNCE_CYC(DEB),
        .LONG_CYC    (LONG),
        .BLINK_CYC   (BLINK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .key_state(key_state),
        .key_press(key_press),
        .key_click(key_click),
        .key_long (key_long),
        .led_mode (led_mode),
        .led      (led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts and last-seen cycle of every pulse.
    int n_press[NK], n_click[NK], n_long[NK];
    int t_press[NK], t_click[NK], t_long[NK];
    initial begin
        for (int k = 0; k < NK; k++) begin
            n_press[k] = 0; n_click[k] = 0; n_long[k] = 0;
            t_press[k] = -1; t_click[k] = -1; t_long[k] = -1;
        end
    end
    always @(negedge clk) begin
        for (int k = 0; k < NK; k++) begin
            if (key_press[k]) begin n_press[k] = n_press[k] + 1; t_press[k] = cyc; end
            if (key_click[k]) begin n_click[k] = n_click[k] + 1; t_click[k] = cyc; end
            if (key_long[k])  begin n_long[k]  = n_long[k] + 1;  t_long[k]  = cyc; end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int b_press[NK], b_click[NK], b_long[NK];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic snap();
        for (int k = 0; k < NK; k++) begin
            b_press[k] = n_press[k]; b_click[k] = n_click[k]; b_long[k] = n_long[k];
        end
    endtask

    // Hold the masked keys low for exactly `low` sampled cycles, then release.
    task automatic press_keys(input logic [NK-1:0] mask, input int low, input int settle,
                              output int c0);
        tick_wait(1);
        key_in = key_in & ~mask;
        c0 = cyc;
        wait_until(c0 + low);
        key_in = key_in | mask;
        tick_wait(settle);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key_in = '1;
        tick_wait(3);
        rst_n = 1'b1;
        tick_wait(2);
    endtask

    task automatic check_idle(input string tag, input int exp_led, input int exp_mode);
        check({tag, " led"}, int'(led), exp_led);
        check({tag, " mode"}, int'(led_mode), exp_mode);
        check({tag, " key_state"}, int'(key_state), 15);
    endtask

    typedef struct {
        logic [NK-1:0] mask;
        int            low;
        int            exp_press;
        int            exp_click;
        int            exp_long;
        int            exp_led;
    } vec_t;

    vec_t vecs[12];

    // Reference model state for the random phase.
    int m_cnt;
    int e_press[NK], e_click[NK], e_long[NK];

    // Debounce needs DEB stable low samples; a long press needs LONG more samples
    // counted from the confirming one.
    task automatic model_apply(input logic [NK-1:0] mask, input int d);
        logic [NK-1:0] clk_ev, long_ev;
        clk_ev = '0;
        long_ev = '0;
        for (int k = 0; k < NK; k++) begin
            if (mask[k] && d >= DEB) begin
                e_press[k]++;
                if (d >= DEB + LONG - 1) begin e_long[k]++; long_ev[k] = 1'b1; end
                else begin e_click[k]++; clk_ev[k] = 1'b1; end
            end
        end
        if (long_ev[1]) begin
            m_cnt = 0;
        end else begin
            if (clk_ev[0] && !clk_ev[1]) m_cnt = (m_cnt + 1) % 16;
            if (clk_ev[1] && !clk_ev[0]) m_cnt = (m_cnt + 15) % 16;
            for (int k = 2; k < NK; k++) begin
                if (clk_ev[k]) m_cnt = m_cnt ^ (1 << ((k - 2) % NL));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    int c0, c1, c2, c3;
    bit found;

    initial begin
        vecs[0]  = '{4'b0001, 7,  0, 0, 0, 0};
        vecs[1]  = '{4'b0001, 8,  1, 1, 0, 1};
        vecs[2]  = '{4'b0001, 20, 1, 1, 0, 2};
        vecs[3]  = '{4'b0010, 20, 1, 1, 0, 1};
        vecs[4]  = '{4'b0100, 20, 1, 1, 0, 0};
        vecs[5]  = '{4'b0010, 20, 1, 1, 0, 15};
        vecs[6]  = '{4'b1000, 20, 1, 1, 0, 13};
        vecs[7]  = '{4'b0011, 20, 1, 1, 0, 13};
        vecs[8]  = '{4'b1100, 20, 1, 1, 0, 14};
        vecs[9]  = '{4'b0001, 46, 1, 1, 0, 15};
        vecs[10] = '{4'b0010, 47, 1, 0, 1, 0};
        vecs[11] = '{4'b0010, 7,  0, 0, 0, 0};

        // Reset state
        tick_wait(2);
        check("reset key_state", int'(key_state), 15);
        check("reset pulses", int'({key_press, key_click, key_long}), 0);
        check("reset led", int'(led), 0);
        check("reset mode", int'(led_mode), 0);
        do_reset();

        // Bounce then stable low: one press, 10 cycles after stable low
        snap();
        tick_wait(1);
        repeat (3) begin
            key_in[0] = 1'b0; c0 = cyc;
            wait_until(c0 + 3);
            key_in[0] = 1'b1;
            wait_until(c0 + 5);
        end
        key_in[0] = 1'b0; c0 = cyc;
        wait_until(c0 + 20);
        key_in[0] = 1'b1;
        tick_wait(16);
        check("bounce press count", n_press[0] - b_press[0], 1);
        check("bounce press latency", t_press[0] - c0, 2 + DEB);
        check("bounce click count", n_click[0] - b_click[0], 1);
        check("bounce long count", n_long[0] - b_long[0], 0);
        check("bounce led", int'(led), 1);

        // Table vectors, from a fresh reset
        do_reset();
        for (int i = 0; i < 12; i++) begin
            snap();
            press_keys(vecs[i].mask, vecs[i].low, 16, c0);
            for (int k = 0; k < NK; k++) begin
                check($sformatf("vec%0d press[%0d]", i, k), n_press[k] - b_press[k],
                      vecs[i].mask[k] ? vecs[i].exp_press : 0);
                check($sformatf("vec%0d click[%0d]", i, k), n_click[k] - b_click[k],
                      vecs[i].mask[k] ? vecs[i].exp_click : 0);
                check($sformatf("vec%0d long[%0d]", i, k), n_long[k] - b_long[k],
                      vecs[i].mask[k] ? vecs[i].exp_long : 0);
            end
            check_idle($sformatf("vec%0d", i), vecs[i].exp_led, 0);
        end

        // Wrap: decrement from 0, then sixteen increments return to the start
        do_reset();
        press_keys(4'b0010, 12, 16, c0);
        check("wrap dec led", int'(led), 15);
        repeat (16) press_keys(4'b0001, 12, 16, c0);
        check("wrap inc16 led", int'(led), 15);

        // BLINK: cnt=3, key0 held 60 cycles
        do_reset();
        repeat (3) press_keys(4'b0001, 12, 16, c0);
        snap();
        tick_wait(1);
        key_in[0] = 1'b0; c0 = cyc;
        wait_until(c0 + 54);
        check("blink long time", t_long[0] - c0, 2 + DEB + LONG - 1);
        check("blink mode", int'(led_mode), 1);
        check("blink phase0 led", int'(led), 3);
        wait_until(c0 + 60);
        key_in[0] = 1'b1;
        wait_until(c0 + 64);
        check("blink phase1 led", int'(led), 0);
        wait_until(c0 + 74);
        check("blink phase2 led", int'(led), 3);
        wait_until(c0 + 84);
        check("blink phase3 led", int'(led), 0);
        check("blink long count", n_long[0] - b_long[0], 1);
        check("blink click count", n_click[0] - b_click[0], 0);

        // ROTATE: second long on key0
        tick_wait(1);
        key_in[0] = 1'b0; c2 = cyc;
        wait_until(c2 + 55);
        check("rotate mode", int'(led_mode), 2);
        check("rotate step0", int'(led), 4'b0011);
        wait_until(c2 + 60);
        key_in[0] = 1'b1;
        wait_until(c2 + 65);
        check("rotate step1", int'(led), 4'b0110);
        wait_until(c2 + 75);
        check("rotate step2", int'(led), 4'b1100);
        wait_until(c2 + 85);
        check("rotate step3", int'(led), 4'b1001);
        snap();
        press_keys(4'b0100, 12, 0, c0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (n_click[2] != b_click[2]) found = 1'b1;
            else tick_wait(1);
        end
        check("rotate key2 click seen", int'(found), 1);
        tick_wait(1);
        check("rotate reload led", int'(led), 4'b0010);

        // Same-cycle events
        do_reset();
        repeat (2) press_keys(4'b0001, 12, 16, c0);
        press_keys(4'b0011, 20, 16, c0);
        check("inc+dec same cycle led", int'(led), 2);
        press_keys(4'b0001, 50, 16, c0);
        check("pre-clear mode", int'(led_mode), 1);
        snap();
        tick_wait(1);
        key_in[1:0] = 2'b00; c1 = cyc;
        wait_until(c1 + 39);
        key_in[0] = 1'b1;
        wait_until(c1 + 47);
        key_in[1] = 1'b1;
        tick_wait(16);
        check("clear click0 time", t_click[0] - c1, 49);
        check("clear long1 time", t_long[1] - c1, 49);
        check("clear click0 count", n_click[0] - b_click[0], 1);
        check_idle("clear", 0, 0);

        // Reset while a key is held down
        press_keys(4'b0001, 12, 16, c0);
        tick_wait(1);
        key_in[0] = 1'b0; c3 = cyc;
        wait_until(c3 + 15);
        check("held key_state", int'(key_state[0]), 0);
        check("held led", int'(led), 1);
        snap();
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset key_state", int'(key_state), 15);
        check("async reset pulses", int'({key_press, key_click, key_long}), 0);
        check("async reset led", int'(led), 0);
        check("async reset mode", int'(led_mode), 0);
        tick_wait(5);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick_wait(1);
            if (n_press[0] != b_press[0]) found = 1'b1;
        end
        check("fresh press after reset", int'(found), 1);
        key_in[0] = 1'b1;
        tick_wait(16);
        check("post-reset press count", n_press[0] - b_press[0], 1);
        check("post-reset click count", n_click[0] - b_click[0], 1);
        check("post-reset led", int'(led), 1);

        // Random presses against the reference model (STATIC mode only)
        do_reset();
        snap();
        m_cnt = 0;
        for (int k = 0; k < NK; k++) begin e_press[k] = 0; e_click[k] = 0; e_long[k] = 0; end
        for (int n = 0; n < 30; n++) begin
            int            op, k, d;
            logic [NK-1:0] mask;
            op = $urandom_range(0, 5);
            k = $urandom_range(0, NK - 1);
            case (op)
                0, 1, 2: begin mask = NK'(1 << k); d = $urandom_range(DEB, 40); end
                3:       begin mask = NK'(1 << k); d = $urandom_range(1, DEB - 1); end
                4: begin
                    mask = ($urandom_range(0, 1) != 0) ? 4'b0011 : 4'b1100;
                    d = $urandom_range(DEB, 40);
                end
                default: begin mask = 4'b0010; d = $urandom_range(DEB + LONG - 1, 60); end
            endcase
            press_keys(mask, d, 16, c0);
            model_apply(mask, d);
            check_idle($sformatf("rand%0d", n), m_cnt, 0);
        end
        for (int k = 0; k < NK; k++) begin
            check($sformatf("rand press[%0d]", k), n_press[k] - b_press[k], e_press[k]);
            check($sformatf("rand click[%0d]", k), n_click[k] - b_click[k], e_click[k]);
            check($sformatf("rand long[%0d]", k), n_long[k] - b_long[k], e_long[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
